// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// Field widths are derived from the instruction layout parameters.
interface decode_stage_if #(
  parameter int INSTR_W = 10,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4
);
  localparam int REM   = INSTR_W - OPC_W;
  localparam int IMM_W = REM + INSTR_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_ra;
  logic [REM-2:0]     out_f51;
  logic [IMM_W-1:0]   out_imm;
  logic [1:0]         out_lo2;
  logic               out_arg2;
  logic               out_bit0;
  logic               out_ext;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_ra, out_f51, out_imm,
           out_lo2, out_arg2, out_bit0, out_ext, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_ra, out_f51, out_imm,
           out_lo2, out_arg2, out_bit0, out_ext, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Single-entry instruction decode stage with a two-word extended-immediate form.
// Fields are sliced combinationally and held in one output register stage.
module decode_stage #(
  parameter int               INSTR_W = 10,
  parameter int               OPC_W   = 4,
  parameter int               REG_W   = 4,
  parameter logic [OPC_W-1:0] EXT_OPC = 4'hF,
  parameter int               NUM_OPC = 14,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    dec,
  output logic [CNT_W-1:0] dec_count
);
  localparam int REM   = INSTR_W - OPC_W;
  localparam int IMM_W = REM + INSTR_W;
  localparam logic [OPC_W:0] NUM_OPC_L = NUM_OPC[OPC_W:0];

  generate
    if (REM < REG_W || REM < 2) begin : g_bad_width
      $error("decode_stage: INSTR_W-OPC_W must be >= REG_W and >= 2");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WAIT_EXT} state_t;

  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return ({1'b0, opc} >= NUM_OPC_L) && (opc != EXT_OPC);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [INSTR_W-1:0] r_pend_p0;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_load;
  logic               w_store;
  logic               w_ext;
  logic [INSTR_W-1:0] w_word;
  logic [IMM_W-1:0]   w_imm;
  logic [OPC_W-1:0]   w_in_opc;

  logic               r_vld_p1;
  logic [OPC_W-1:0]   r_opc_p1;
  logic [REG_W-1:0]   r_ra_p1;
  logic [REM-2:0]     r_f51_p1;
  logic [IMM_W-1:0]   r_imm_p1;
  logic [1:0]         r_lo2_p1;
  logic               r_arg2_p1;
  logic               r_bit0_p1;
  logic               r_ext_p1;
  logic               r_ill_p1;
  logic [CNT_W-1:0]   r_cnt;

  assign w_in_ready = !flush && (!r_vld_p1 || dec.out_ready);
  assign w_accept   = dec.in_valid && w_in_ready;
  assign w_in_opc   = dec.in_instr[INSTR_W-1 -: OPC_W];

  // p0: select the word to decode; an extended pair takes its fields from the prefix
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_store     = 1'b0;
    w_ext       = 1'b0;
    w_word      = dec.in_instr;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (w_in_opc == EXT_OPC) begin
            w_store     = 1'b1;
            w_state_nxt = S_WAIT_EXT;
          end else begin
            w_load = 1'b1;
          end
        end
        S_WAIT_EXT: begin
          w_load      = 1'b1;
          w_ext       = 1'b1;
          w_word      = r_pend_p0;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_imm = w_ext ? {r_pend_p0[REM-1:0], dec.in_instr}
                       : {{INSTR_W{1'b0}}, w_word[REM-1:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) r_pend_p0 <= '0;
    else if (w_store)   r_pend_p0 <= dec.in_instr;
  end

  // p1: registered decode result and emitted-entry counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_opc_p1  <= '0;
      r_ra_p1   <= '0;
      r_f51_p1  <= '0;
      r_imm_p1  <= '0;
      r_lo2_p1  <= '0;
      r_arg2_p1 <= 1'b0;
      r_bit0_p1 <= 1'b0;
      r_ext_p1  <= 1'b0;
      r_ill_p1  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (flush)               r_vld_p1 <= 1'b0;
      else if (w_load)         r_vld_p1 <= 1'b1;
      else if (dec.out_ready)  r_vld_p1 <= 1'b0;
      if (w_load) begin
        r_opc_p1  <= w_word[INSTR_W-1 -: OPC_W];
        r_ra_p1   <= w_word[REM-1 -: REG_W];
        r_f51_p1  <= w_word[REM-1:1];
        r_imm_p1  <= w_imm;
        r_lo2_p1  <= w_word[1:0];
        r_arg2_p1 <= w_word[1];
        r_bit0_p1 <= w_word[0];
        r_ext_p1  <= w_ext;
        r_ill_p1  <= is_illegal(w_word[INSTR_W-1 -: OPC_W]);
      end
      if (!flush && r_vld_p1 && dec.out_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dec.in_ready    = w_in_ready;
  assign dec.out_valid   = r_vld_p1;
  assign dec.out_opcode  = r_opc_p1;
  assign dec.out_ra      = r_ra_p1;
  assign dec.out_f51     = r_f51_p1;
  assign dec.out_imm     = r_imm_p1;
  assign dec.out_lo2     = r_lo2_p1;
  assign dec.out_arg2    = r_arg2_p1;
  assign dec.out_bit0    = r_bit0_p1;
  assign dec.out_ext     = r_ext_p1;
  assign dec.out_illegal = r_ill_p1;
  assign dec_count       = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized stream checked
// against an arithmetic decode model and a transaction-level handshake model.
module tb_decode_stage;
  localparam int INSTR_W = 10;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int NUM_OPC = 14;
  localparam int CNT_W   = 16;

  typedef logic [34:0] fld_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] dec_count;
  int               n_chk = 0;
  int               n_err = 0;

  decode_stage_if #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W)) dec();

  decode_stage #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .EXT_OPC(4'hF),
    .NUM_OPC(NUM_OPC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .dec(dec.slave), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  function automatic fld_t pack(input int opc, input int ra, input int f51, input int imm,
                                input int lo2, input int arg2, input int bit0,
                                input int ext, input int ill);
    return {4'(opc), 4'(ra), 5'(f51), 16'(imm), 2'(lo2), 1'(arg2), 1'(bit0), 1'(ext), 1'(ill)};
  endfunction

  // Reference decode computed with plain arithmetic on the word value
  function automatic fld_t model_dec(input logic [9:0] w, input bit e, input logic [9:0] w2);
    int wi, opc, imm;
    wi  = int'(w);
    opc = wi / 64;
    imm = e ? (wi % 64) * 1024 + int'(w2) : wi % 64;
    return pack(opc, (wi / 4) % 16, (wi / 2) % 32, imm, wi % 4, (wi / 2) % 2, wi % 2,
                e ? 1 : 0, (opc >= NUM_OPC && opc != 15) ? 1 : 0);
  endfunction

  function automatic fld_t fields();
    return {dec.out_opcode, dec.out_ra, dec.out_f51, dec.out_imm, dec.out_lo2,
            dec.out_arg2, dec.out_bit0, dec.out_ext, dec.out_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [9:0] w, input logic r);
    dec.in_valid  = v;
    dec.in_instr  = w;
    dec.out_ready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 10'h0, 1'b0);
    flush = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dec.out_valid); end
    n_chk++; if (fields() !== '0) begin n_err++; $display("FAIL reset_fields got %h exp 0", fields()); end
    n_chk++; if (dec_count !== 16'h0) begin n_err++; $display("FAIL reset_count got %h exp 0", dec_count); end
    n_chk++; if (dec.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", dec.in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 10'h0DB, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b1);
    n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", dec.out_valid); end
    n_chk++; if (fields() !== pack(3, 6, 'h0D, 'h1B, 3, 1, 1, 0, 0)) begin n_err++; $display("FAIL basic_fields got %h exp %h", fields(), pack(3, 6, 'h0D, 'h1B, 3, 1, 1, 0, 0)); end
    n_chk++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL basic_count_pre got %0d exp 0", dec_count); end
    step();
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b exp 0", dec.out_valid); end
    n_chk++; if (dec_count !== 16'd1) begin n_err++; $display("FAIL basic_count got %0d exp 1", dec_count); end
  endtask

  task automatic test_extended();
    do_reset();
    drive(1'b1, 10'h3C5, 1'b1);
    step();
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL ext_first_word got valid %b exp 0", dec.out_valid); end
    drive(1'b1, 10'h2AA, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b1);
    n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL ext_valid got %b exp 1", dec.out_valid); end
    n_chk++; if (fields() !== pack(15, 1, 2, 'h16AA, 1, 0, 1, 1, 0)) begin n_err++; $display("FAIL ext_fields got %h exp %h", fields(), pack(15, 1, 2, 'h16AA, 1, 0, 1, 1, 0)); end
    step();
    n_chk++; if (dec_count !== 16'd1) begin n_err++; $display("FAIL ext_count got %0d exp 1", dec_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 10'h380, 1'b0);
    step();
    drive(1'b0, 10'h0, 1'b0);
    n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL illegal_valid got %b exp 1", dec.out_valid); end
    n_chk++; if (fields() !== pack(14, 0, 0, 0, 0, 0, 0, 0, 1)) begin n_err++; $display("FAIL illegal_fields got %h exp %h", fields(), pack(14, 0, 0, 0, 0, 0, 0, 0, 1)); end
    n_chk++; if (dec.in_ready !== 1'b0) begin n_err++; $display("FAIL illegal_in_ready got %b exp 0", dec.in_ready); end
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_chk++; if (dec_count !== 16'd1) begin n_err++; $display("FAIL illegal_count got %0d exp 1", dec_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 10'h0DB, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'h041, 1'b0);
      #1;
      n_chk++; if (dec.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, dec.in_ready); end
      n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", i, dec.out_valid); end
      n_chk++; if (fields() !== pack(3, 6, 'h0D, 'h1B, 3, 1, 1, 0, 0)) begin n_err++; $display("FAIL bp_hold[%0d] got %h", i, fields()); end
      step();
    end
    drive(1'b1, 10'h041, 1'b1);
    #1;
    n_chk++; if (dec.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", dec.in_ready); end
    step();
    drive(1'b0, 10'h0, 1'b1);
    n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_no_bubble got %b exp 1", dec.out_valid); end
    n_chk++; if (fields() !== pack(1, 0, 0, 1, 1, 0, 1, 0, 0)) begin n_err++; $display("FAIL bp_new_fields got %h exp %h", fields(), pack(1, 0, 0, 1, 1, 0, 1, 0, 0)); end
    n_chk++; if (dec_count !== 16'd1) begin n_err++; $display("FAIL bp_count1 got %0d exp 1", dec_count); end
    step();
    n_chk++; if (dec_count !== 16'd2) begin n_err++; $display("FAIL bp_count2 got %0d exp 2", dec_count); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 10'h3C5, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b1);
    flush = 1'b1;
    #1;
    n_chk++; if (dec.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", dec.in_ready); end
    step();
    flush = 1'b0;
    drive(1'b1, 10'h0DB, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b0);
    n_chk++; if (fields() !== pack(3, 6, 'h0D, 'h1B, 3, 1, 1, 0, 0)) begin n_err++; $display("FAIL flush_pending_drop got %h", fields()); end
    n_chk++; if (dec.out_valid !== 1'b1) begin n_err++; $display("FAIL flush_post_valid got %b exp 1", dec.out_valid); end
    flush = 1'b1;
    drive(1'b1, 10'h041, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 10'h0, 1'b0);
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", dec.out_valid); end
    n_chk++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", dec_count); end
    step();
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_accept got %b exp 0", dec.out_valid); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    force dut.r_cnt = 16'hFFFF;
    step();
    release dut.r_cnt;
    step();
    n_chk++; if (dec_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preset got %h exp ffff", dec_count); end
    drive(1'b1, 10'h0DB, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b1);
    step();
    n_chk++; if (dec_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count got %h exp 0000", dec_count); end
    drive(1'b1, 10'h0DB, 1'b1);
    step();
    drive(1'b1, 10'h3C5, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++; if (dec.out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got %b exp 0", dec.out_valid); end
    n_chk++; if (fields() !== '0) begin n_err++; $display("FAIL midreset_fields got %h exp 0", fields()); end
    n_chk++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL midreset_count got %0d exp 0", dec_count); end
    drive(1'b1, 10'h0DB, 1'b1);
    step();
    drive(1'b0, 10'h0, 1'b0);
    n_chk++; if (fields() !== pack(3, 6, 'h0D, 'h1B, 3, 1, 1, 0, 0)) begin n_err++; $display("FAIL midreset_decode got %h", fields()); end
  endtask

  task automatic test_random();
    bit         mv, mpend, load, consume, exp_rdy, iv, ordy;
    logic [9:0] pw, w;
    fld_t       mexp;
    int         mcnt;
    do_reset();
    mv = 0; mpend = 0; mcnt = 0; pw = '0; mexp = '0;
    for (int c = 0; c < 600; c++) begin
      n_chk++; if (dec.out_valid !== mv) begin n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, dec.out_valid, mv); end
      if (mv) begin
        n_chk++; if (fields() !== mexp) begin n_err++; $display("FAIL rnd_fields c%0d got %h exp %h", c, fields(), mexp); end
      end
      n_chk++; if (dec_count !== 16'(mcnt)) begin n_err++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, dec_count, mcnt); end
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      w    = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) w = w | 10'h3C0;
      drive(iv, w, ordy);
      #1;
      exp_rdy = !mv || ordy;
      n_chk++; if (dec.in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, dec.in_ready, exp_rdy); end
      consume = mv && ordy;
      if (consume) mcnt = (mcnt + 1) % 65536;
      load = 0;
      if (iv && exp_rdy) begin
        if (mpend) begin
          mexp = model_dec(pw, 1'b1, w); mpend = 0; load = 1;
        end else if (int'(w) / 64 == 15) begin
          pw = w; mpend = 1;
        end else begin
          mexp = model_dec(w, 1'b0, 10'h0); load = 1;
        end
      end
      mv = load ? 1'b1 : (consume ? 1'b0 : mv);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 10'h0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_extended();
    test_illegal();
    test_backpressure();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
